// File: rtl/g4_table_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : g4_upd_pkg
// Purpose  : Shared constants for the G4 rule-table update engine: opcodes,
//            response codes, entry field offsets, the tombstone field image
//            and the controller state encoding.
//            Optional feature macro: G4_UPD_WRITE_VERIFY_EN (adds the two
//            read-back verify states).
// Revision : 1.0 - initial release
// ============================================================================
package g4_upd_pkg;

  // Command opcodes
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Response status codes
  localparam logic [1:0] RSP_OK        = 2'b00;
  localparam logic [1:0] RSP_FULL      = 2'b01;
  localparam logic [1:0] RSP_NOT_FOUND = 2'b10;
  localparam logic [1:0] RSP_FAULT     = 2'b11;

  // Entry layout (171-bit entry, 11-bit indices)
  localparam int NEXT_LSB     = 160;
  localparam int RULE_LSB     = 149;
  localparam int FIELDS_W     = 149;
  localparam int WILD_BIT     = 148;
  localparam int PROTO_LSB    = 140;
  localparam int DPORT_LO_LSB = 124;
  localparam int DPORT_HI_LSB = 108;
  localparam int SPORT_LO_LSB = 92;
  localparam int SPORT_HI_LSB = 76;
  localparam int DPFX_LSB     = 70;
  localparam int DIP_LSB      = 38;
  localparam int SPFX_LSB     = 32;
  localparam int SIP_LSB      = 0;

  // All-ones index terminates a chain
  localparam logic [10:0] NULL_INDEX = 11'h7FF;

  // Tombstone match fields: inverted port ranges (low > high) and no
  // protocol wildcard, so the slot can never match yet its next pointer
  // keeps the chain walkable.
  localparam logic [FIELDS_W-1:0] TOMB_FIELDS = {
    1'b0,            // protocol wildcard
    8'h00,           // protocol
    16'hFFFF,        // dstPort low
    16'h0000,        // dstPort high
    16'hFFFF,        // srcPort low
    16'h0000,        // srcPort high
    76'h0            // prefix lengths and addresses
  };

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INS_WR     = 3'd1,
    S_WALK_RD    = 3'd2,
    S_WALK_CHK   = 3'd3,
    S_DEL_WR     = 3'd4,
    S_RESP       = 3'd5
`ifdef G4_UPD_WRITE_VERIFY_EN
    ,
    S_VERIFY_RD  = 3'd6,
    S_VERIFY_CHK = 3'd7
`endif
  } upd_state_t;

endpackage
`default_nettype wire

// File: rtl/g4_table_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : g4_table_update_ctrl_if
// Purpose   : Command, response and table-port signals of the G4 table
//             update engine. "slave" is the engine, "master" is the host
//             side that issues commands and models the table.
// Revision  : 1.0 - initial release
// ============================================================================
interface g4_table_update_ctrl_if #(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int ENTRY_DATA_WIDTH = 171,
  parameter int COMMAND_BIT_LEN  = 2
);
  localparam int FIELD_W = ENTRY_DATA_WIDTH - 2*INDEX_BIT_LEN;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [COMMAND_BIT_LEN-1:0]  cmd_op;
  logic [INDEX_BIT_LEN-1:0]    cmd_head_index;
  logic [INDEX_BIT_LEN-1:0]    cmd_rule_id;
  logic [FIELD_W-1:0]          cmd_fields;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [1:0]                  rsp_status;
  logic [INDEX_BIT_LEN-1:0]    rsp_index;
  logic                        upd_busy;
  logic                        tbl_we;
  logic [ENTRY_DATA_WIDTH-1:0] tbl_din;
  logic [INDEX_BIT_LEN-1:0]    tbl_index;
  logic [INDEX_BIT_LEN-1:0]    tbl_next_index;
  logic [INDEX_BIT_LEN-1:0]    tbl_rule_id;

  modport master (
    output cmd_valid, cmd_op, cmd_head_index, cmd_rule_id, cmd_fields,
    output rsp_ready, tbl_next_index, tbl_rule_id,
    input  cmd_ready, rsp_valid, rsp_status, rsp_index, upd_busy,
    input  tbl_we, tbl_din, tbl_index
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_head_index, cmd_rule_id, cmd_fields,
    input  rsp_ready, tbl_next_index, tbl_rule_id,
    output cmd_ready, rsp_valid, rsp_status, rsp_index, upd_busy,
    output tbl_we, tbl_din, tbl_index
  );
endinterface
`default_nettype wire

// File: rtl/g4_table_update_ctrl_entry_pack.sv
`default_nettype none
// ============================================================================
// Module   : g4_entry_pack
// Purpose  : Combinational builder for a table entry: {next, ruleID, fields},
//            with the match fields replaced by the tombstone image on request.
// Revision : 1.0 - initial release
// ============================================================================
module g4_entry_pack
  import g4_upd_pkg::*;
#(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int ENTRY_DATA_WIDTH = 171
) (
  input  wire logic                                        i_tomb,
  input  wire logic [INDEX_BIT_LEN-1:0]                    i_next_index,
  input  wire logic [INDEX_BIT_LEN-1:0]                    i_rule_id,
  input  wire logic [ENTRY_DATA_WIDTH-2*INDEX_BIT_LEN-1:0] i_fields,
  output logic      [ENTRY_DATA_WIDTH-1:0]                 o_entry
);
  localparam int FIELD_W = ENTRY_DATA_WIDTH - 2*INDEX_BIT_LEN;

  // Assemble the entry; tombstones keep next/ruleID so the chain stays intact
  always_comb begin
    o_entry = {i_next_index, i_rule_id, i_fields};
    if (i_tomb) begin
      o_entry = {i_next_index, i_rule_id, FIELD_W'(TOMB_FIELDS)};
    end
  end
endmodule
`default_nettype wire

// File: rtl/g4_table_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : g4_table_update_ctrl
// Purpose  : Write-side engine for the G4 protocol-other rule tables.
//            INSERT bump-allocates a slot and writes a new chain head;
//            DELETE walks the chain via the table's registered read-back
//            and tombstones the matching slot. Owns the table port while
//            upd_busy is high.
//            Optional feature macro: G4_UPD_WRITE_VERIFY_EN (read back each
//            written slot and report FAULT on mismatch).
// Revision : 1.0 - initial release
// ============================================================================
module g4_table_update_ctrl
  import g4_upd_pkg::*;
#(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int ENTRY_DATA_WIDTH = 171,
  parameter int TABLE_ENTRY_SIZE = 1023,
  parameter int FIRST_FREE       = 0,
  parameter int MAX_WALK         = 64,
  parameter int COMMAND_BIT_LEN  = 2
) (
  input wire logic               clk,
  input wire logic               rst_n,
  g4_table_update_ctrl_if.slave  bus
);
  localparam int PTR_W   = INDEX_BIT_LEN + 1;
  localparam int HOP_W   = $clog2(MAX_WALK + 1);
  localparam int FIELD_W = ENTRY_DATA_WIDTH - 2*INDEX_BIT_LEN;
  localparam logic [INDEX_BIT_LEN-1:0] C_NULL = '1;

  upd_state_t                  r_state;
  logic [PTR_W-1:0]            r_free_ptr;
  logic [INDEX_BIT_LEN-1:0]    r_rule_id;
  logic [INDEX_BIT_LEN-1:0]    r_cur;
  logic [HOP_W-1:0]            r_hops;
  logic                        r_full;
`ifdef G4_UPD_WRITE_VERIFY_EN
  logic [INDEX_BIT_LEN-1:0]    r_wr_next;
`endif

  logic                        r_cmd_ready;
  logic                        r_rsp_valid;
  logic [1:0]                  r_rsp_status;
  logic [INDEX_BIT_LEN-1:0]    r_rsp_index;
  logic                        r_upd_busy;
  logic                        r_tbl_we;
  logic [ENTRY_DATA_WIDTH-1:0] r_tbl_din;
  logic [INDEX_BIT_LEN-1:0]    r_tbl_index;

  logic                        w_full;
  logic                        w_pack_tomb;
  logic [INDEX_BIT_LEN-1:0]    w_pack_next;
  logic [INDEX_BIT_LEN-1:0]    w_pack_rule;
  logic [ENTRY_DATA_WIDTH-1:0] w_entry;
  logic [FIELD_W-1:0]          w_pack_fields;

  assign w_full        = (r_free_ptr > PTR_W'(TABLE_ENTRY_SIZE));
  assign w_pack_fields = bus.cmd_fields;

  // Pack sources: command inputs at accept, table read-back for tombstones
  always_comb begin
    w_pack_tomb = (r_state != S_IDLE);
    w_pack_next = bus.cmd_head_index;
    w_pack_rule = bus.cmd_rule_id;
    if (w_pack_tomb) begin
      w_pack_next = bus.tbl_next_index;
      w_pack_rule = r_rule_id;
    end
  end

  g4_entry_pack #(
    .INDEX_BIT_LEN    (INDEX_BIT_LEN),
    .ENTRY_DATA_WIDTH (ENTRY_DATA_WIDTH)
  ) u_pack (
    .i_tomb       (w_pack_tomb),
    .i_next_index (w_pack_next),
    .i_rule_id    (w_pack_rule),
    .i_fields     (w_pack_fields),
    .o_entry      (w_entry)
  );

  // Control FSM with registered outputs; write strobes are set on the
  // transition into the write state so they appear for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_free_ptr   <= PTR_W'(FIRST_FREE);
      r_rule_id    <= '0;
      r_cur        <= '0;
      r_hops       <= '0;
      r_full       <= 1'b0;
`ifdef G4_UPD_WRITE_VERIFY_EN
      r_wr_next    <= '0;
`endif
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= RSP_OK;
      r_rsp_index  <= '0;
      r_upd_busy   <= 1'b0;
      r_tbl_we     <= 1'b0;
      r_tbl_din    <= '0;
      r_tbl_index  <= '0;
    end else begin
      r_tbl_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_upd_busy  <= 1'b0;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready  <= 1'b0;
            r_upd_busy   <= 1'b1;
            r_rule_id    <= bus.cmd_rule_id;
            r_rsp_index  <= '0;
            r_rsp_status <= RSP_OK;
            case (bus.cmd_op)
              OP_NOP: begin
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end
              OP_INSERT: begin
                // Capacity is decided before any write is issued
                r_full  <= w_full;
                r_state <= S_INS_WR;
`ifdef G4_UPD_WRITE_VERIFY_EN
                r_wr_next <= bus.cmd_head_index;
`endif
                if (!w_full) begin
                  r_tbl_we    <= 1'b1;
                  r_tbl_index <= r_free_ptr[INDEX_BIT_LEN-1:0];
                  r_tbl_din   <= w_entry;
                  r_rsp_index <= r_free_ptr[INDEX_BIT_LEN-1:0];
                end
              end
              OP_DELETE: begin
                if (bus.cmd_head_index == C_NULL) begin
                  r_rsp_status <= RSP_NOT_FOUND;
                  r_rsp_valid  <= 1'b1;
                  r_state      <= S_RESP;
                end else begin
                  r_cur       <= bus.cmd_head_index;
                  r_hops      <= '0;
                  r_tbl_index <= bus.cmd_head_index;
                  r_state     <= S_WALK_RD;
                end
              end
              default: begin
                r_rsp_status <= RSP_FAULT;
                r_rsp_valid  <= 1'b1;
                r_state      <= S_RESP;
              end
            endcase
          end
        end

        S_INS_WR: begin
          if (r_full) begin
            r_rsp_status <= RSP_FULL;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_free_ptr <= r_free_ptr + PTR_W'(1);
`ifdef G4_UPD_WRITE_VERIFY_EN
            r_state    <= S_VERIFY_RD;
`else
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
`endif
          end
        end

        S_WALK_RD: begin
          r_state <= S_WALK_CHK;
        end

        S_WALK_CHK: begin
          if (bus.tbl_rule_id == r_rule_id) begin
            r_tbl_we    <= 1'b1;
            r_tbl_din   <= w_entry;
            r_rsp_index <= r_cur;
            r_state     <= S_DEL_WR;
`ifdef G4_UPD_WRITE_VERIFY_EN
            r_wr_next   <= bus.tbl_next_index;
`endif
          end else if (bus.tbl_next_index == C_NULL) begin
            r_rsp_status <= RSP_NOT_FOUND;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_hops == HOP_W'(MAX_WALK - 1)) begin
            // Hop budget exhausted: treat as a corrupted (possibly cyclic) chain
            r_rsp_status <= RSP_FAULT;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cur       <= bus.tbl_next_index;
            r_tbl_index <= bus.tbl_next_index;
            r_hops      <= r_hops + HOP_W'(1);
            r_state     <= S_WALK_RD;
          end
        end

        S_DEL_WR: begin
`ifdef G4_UPD_WRITE_VERIFY_EN
          r_state     <= S_VERIFY_RD;
`else
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
`endif
        end

`ifdef G4_UPD_WRITE_VERIFY_EN
        S_VERIFY_RD: begin
          r_state <= S_VERIFY_CHK;
        end

        S_VERIFY_CHK: begin
          if ((bus.tbl_rule_id != r_rule_id) || (bus.tbl_next_index != r_wr_next)) begin
            r_rsp_status <= RSP_FAULT;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
`endif

        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_upd_busy  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_rsp_status;
  assign bus.rsp_index  = r_rsp_index;
  assign bus.upd_busy   = r_upd_busy;
  assign bus.tbl_we     = r_tbl_we;
  assign bus.tbl_din    = r_tbl_din;
  assign bus.tbl_index  = r_tbl_index;

endmodule
`default_nettype wire

// File: doc/g4_table_update_ctrl.md
Name: g4_table_update_ctrl

Overview:
- Write-side engine for the G4 protocol-other rule tables. The search path reads the tables; this block writes them.
- Accepts insert/delete commands through a valid/ready handshake.
- Walks a table's linked chain through the table's registered next_index/ruleID read outputs, then drives we/din/search_index.
- Top level muxes the table port to this block while upd_busy=1.

Parameters:
- INDEX_BIT_LEN, 11, width of slot index, ruleID and next pointer
- ENTRY_DATA_WIDTH, 171, table entry width
- TABLE_ENTRY_SIZE, 1023, highest valid slot
- FIRST_FREE, 0, first slot the allocator hands out (slots below it are preloaded)
- MAX_WALK, 64, maximum chain hops per delete
- COMMAND_BIT_LEN, 2, opcode width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  COMMAND_BIT_LEN  00 NOP, 01 INSERT, 10 DELETE, 11 reserved
- cmd_head_index  in  INDEX_BIT_LEN  current chain head (all-ones = empty chain)
- cmd_rule_id  in  INDEX_BIT_LEN  rule ID
- cmd_fields  in  ENTRY_DATA_WIDTH-22  match fields [148:0] of the entry
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_status  out  2  00 OK, 01 FULL, 10 NOT_FOUND, 11 FAULT
- rsp_index  out  INDEX_BIT_LEN  insert: new head slot; delete: tombstoned slot
- upd_busy  out  1  table port owned by this block
- tbl_we  out  1  table write enable
- tbl_din  out  ENTRY_DATA_WIDTH  table write data
- tbl_index  out  INDEX_BIT_LEN  table search_index
- tbl_next_index  in  INDEX_BIT_LEN  table next_index (valid 1 cycle after tbl_index)
- tbl_rule_id  in  INDEX_BIT_LEN  ruleID read-back (valid 1 cycle after tbl_index)

Behaviour:
- Entry layout, fixed:
  - [170:160] next pointer
  - [159:149] ruleID
  - [148] protocol wildcard
  - [147:140] protocol
  - [139:124] dstPort low, [123:108] dstPort high
  - [107:92] srcPort low, [91:76] srcPort high
  - [75:70], [37:32] prefix lengths
  - [69:38] dstIP, [31:0] srcIP
- NULL = all-ones index.
- Reset values: all outputs 0; state IDLE; free_ptr = FIRST_FREE. Reset mid-operation abandons the command with no response; tbl_we drops immediately.
- FSM states: IDLE, INS_WR, WALK_RD, WALK_CHK, DEL_WR, RESP.
- IDLE:
  - cmd_ready=1 and upd_busy=0; cmd_ready is 0 in every other state.
  - On accept, latch all command fields.
  - NOP → RESP with OK.
  - Reserved op → RESP with FAULT.
  - INSERT → INS_WR.
  - DELETE with head=NULL → RESP with NOT_FOUND; otherwise cur=head, hops=0, → WALK_RD.
- INS_WR (1 cycle):
  - If free_ptr > TABLE_ENTRY_SIZE → RESP with FULL, no write.
  - Otherwise tbl_we=1, tbl_index=free_ptr, tbl_din={head, rule_id, fields}.
  - rsp_index=free_ptr; free_ptr increments; → RESP with OK.
  - Latency: accept at cycle 0, write at cycle 1, rsp_valid at cycle 2.
- WALK_RD: tbl_index=cur, tbl_we=0; → WALK_CHK.
- WALK_CHK: sample tbl_rule_id and tbl_next_index.
  - Rule ID match → DEL_WR.
  - Else if next=NULL → RESP with NOT_FOUND.
  - Else if hops+1 == MAX_WALK → RESP with FAULT.
  - Else cur=next, hops++, → WALK_RD.
  - Each hop costs 2 cycles.
- DEL_WR: tbl_we=1, tbl_index=cur, tbl_din = tombstone {next, rule_id, TOMB_FIELDS}. TOMB_FIELDS sets both port ranges to low=16'hFFFF, high=16'h0000 and wildcard=0, so the entry can never match while the chain stays intact. rsp_index=cur; → RESP with OK.
- RESP: rsp_valid held until rsp_ready; then → IDLE. A new command is accepted no earlier than the cycle after the response is consumed.
- tbl_we is asserted in INS_WR/DEL_WR only, for exactly 1 cycle.
- upd_busy=1 in every state except IDLE.
- Tombstoned slots are not reclaimed: the allocator only bumps. The FULL check happens before any write.

Optional Feature:
- Macro G4_UPD_WRITE_VERIFY_EN.
- Defined: after INS_WR/DEL_WR, insert state VERIFY_RD (tbl_index=slot), then VERIFY_CHK. VERIFY_CHK compares tbl_rule_id and tbl_next_index with the written values; a mismatch gives FAULT. Adds 2 cycles per write.
- Undefined: no read-back; status comes straight from the write state.

Decomposition:
- Package g4_upd_pkg holds:
  - opcode constants and status constants
  - field bit offsets
  - NULL_INDEX
  - TOMB_FIELDS
  - FSM state enum
- One sub-module, g4_entry_pack: combinational build of normal and tombstone entries from next/ruleID/fields.

Test Plan:
- INSERT head=NULL, rule=5, FIRST_FREE=0 → cycle-1 write at index 0, din[170:160]=2047, din[159:149]=5; rsp OK, rsp_index=0 at cycle 2.
- Three INSERTs chaining heads (rules 1,2,3) then DELETE rule 1 from head=2 → reads slots 2,1,0, tombstone written at 0 keeping next=2047; rsp OK, rsp_index=0.
- DELETE rule 9 on that chain → 3 hops then NOT_FOUND, no tbl_we.
- FIRST_FREE=1023: two INSERTs → first OK at 1023, second FULL with no write.
- Table model with a cyclic chain (0→1→0), MAX_WALK=4, delete absent rule → FAULT after 4 hops.
- rsp_ready held low 10 cycles with cmd_valid high → cmd_ready stays 0; rst_n asserted during WALK_RD → tbl_we=0 and rsp_valid=0 immediately, free_ptr=FIRST_FREE.
